// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between mem_bus_arbiter and its SPI client, internal client and memory mux.
// The master modport is the arbiter's view; the slave modport is the view of the surrounding clients.
interface mem_bus_arbiter_if;
   // SPI slave side
   logic        spi_wr_stb;
   logic        spi_rd_stb;
   logic [10:0] spi_addr;
   logic [8:0]  spi_wdata;
   logic [8:0]  spi_rdata;
   logic        spi_rvalid;
   logic        spi_ovf;

   // internal requester side
   logic        int_req;
   logic        int_wr;
   logic [10:0] int_addr;
   logic [8:0]  int_wdata;
   logic        int_gnt;
   logic [8:0]  int_rdata;
   logic        int_rvalid;

   // memory mux side
   logic [10:0] mem_addr;
   logic [8:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [8:0]  mem_rdata;

   // status
   logic        busy;
   logic [15:0] spi_acc_cnt;
   logic [15:0] int_acc_cnt;

   modport master (
      input  spi_wr_stb, spi_rd_stb, spi_addr, spi_wdata,
      output spi_rdata, spi_rvalid, spi_ovf,
      input  int_req, int_wr, int_addr, int_wdata,
      output int_gnt, int_rdata, int_rvalid,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata,
      output busy, spi_acc_cnt, int_acc_cnt
   );

   modport slave (
      output spi_wr_stb, spi_rd_stb, spi_addr, spi_wdata,
      input  spi_rdata, spi_rvalid, spi_ovf,
      output int_req, int_wr, int_addr, int_wdata,
      input  int_gnt, int_rdata, int_rvalid,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata,
      input  busy, spi_acc_cnt, int_acc_cnt
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the internal memory bus between buffered SPI strobes (priority) and a req/gnt internal requester.
// Define MEM_ARB_STATS_EN to add per-source access counters; otherwise the counter ports read 0.
module mem_bus_arbiter #(
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              bit_cnt_rstn,
   mem_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
   typedef enum logic {OWN_SPI, OWN_INT} owner_t;

   localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state;
   owner_t      owner;

   logic        spi_pend;
   logic        spi_wr_q;
   logic [10:0] spi_addr_q;
   logic [8:0]  spi_wdata_q;
   logic        spi_ovf_q;

   logic [3:0]  starve_cnt;
   logic [2:0]  lat_cnt;

   logic [10:0] mem_addr_q;
   logic [8:0]  mem_wdata_q;
   logic        mem_we_q;
   logic        mem_re_q;
   logic        int_gnt_q;
   logic [8:0]  spi_rdata_q;
   logic        spi_rvalid_q;
   logic [8:0]  int_rdata_q;
   logic        int_rvalid_q;

   logic        spi_stb;
   logic        spi_issue;
   logic        int_issue;
   logic        force_int;
   logic        sel_spi;

   assign spi_stb   = bus.spi_wr_stb | bus.spi_rd_stb;
   assign spi_issue = (state == ISSUE) && (owner == OWN_SPI);
   assign int_issue = (state == ISSUE) && (owner == OWN_INT);
   assign force_int = bus.int_req && (starve_cnt == STARVE_LIM);
   assign sel_spi   = spi_pend && !force_int;

   // One-deep SPI buffer: a strobe landing on a still-pending op is dropped
   // unless that op is leaving the buffer in this very cycle.
   // NOTE: all sequential state uses non-blocking assignments so every
   // always_ff samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge bit_cnt_rstn) begin
      if (!bit_cnt_rstn) begin
         spi_pend    <= 1'b0;
         spi_wr_q    <= 1'b0;
         spi_addr_q  <= '0;
         spi_wdata_q <= '0;
         spi_ovf_q   <= 1'b0;
      end else if (spi_stb) begin
         if (!spi_pend || spi_issue) begin
            spi_pend    <= 1'b1;
            spi_wr_q    <= bus.spi_wr_stb;
            spi_addr_q  <= bus.spi_addr;
            spi_wdata_q <= bus.spi_wdata;
         end else begin
            spi_ovf_q   <= 1'b1;
         end
      end else if (spi_issue) begin
         spi_pend <= 1'b0;
      end
   end

   // Arbitration FSM; every bus-facing output is a register written here.
   always_ff @(posedge clk or negedge bit_cnt_rstn) begin
      if (!bit_cnt_rstn) begin
         state        <= IDLE;
         owner        <= OWN_SPI;
         lat_cnt      <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         int_gnt_q    <= 1'b0;
         spi_rdata_q  <= '0;
         spi_rvalid_q <= 1'b0;
         int_rdata_q  <= '0;
         int_rvalid_q <= 1'b0;
      end else begin
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         int_gnt_q    <= 1'b0;
         spi_rvalid_q <= 1'b0;
         int_rvalid_q <= 1'b0;

         case (state)
            IDLE: begin
               if (sel_spi) begin
                  state       <= ISSUE;
                  owner       <= OWN_SPI;
                  mem_addr_q  <= spi_addr_q;
                  mem_wdata_q <= spi_wdata_q;
                  mem_we_q    <= spi_wr_q;
                  mem_re_q    <= !spi_wr_q;
               end else if (bus.int_req) begin
                  state       <= ISSUE;
                  owner       <= OWN_INT;
                  mem_addr_q  <= bus.int_addr;
                  mem_wdata_q <= bus.int_wdata;
                  mem_we_q    <= bus.int_wr;
                  mem_re_q    <= !bus.int_wr;
                  int_gnt_q   <= 1'b1;
               end
            end

            ISSUE: begin
               if (mem_we_q) begin
                  state <= IDLE;
               end else begin
                  lat_cnt <= LAT_LOAD;
                  state   <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (lat_cnt == 3'd0) begin
                  state <= IDLE;
                  if (owner == OWN_SPI) begin
                     spi_rdata_q  <= bus.mem_rdata;
                     spi_rvalid_q <= 1'b1;
                  end else begin
                     int_rdata_q  <= bus.mem_rdata;
                     int_rvalid_q <= 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Counts SPI issues that overtook a waiting internal request.
   always_ff @(posedge clk or negedge bit_cnt_rstn) begin
      if (!bit_cnt_rstn) begin
         starve_cnt <= '0;
      end else if (int_issue) begin
         starve_cnt <= '0;
      end else if (spi_issue && bus.int_req) begin
         if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end else if ((state == IDLE) && !bus.int_req) begin
         starve_cnt <= '0;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [15:0] spi_acc_q;
   logic [15:0] int_acc_q;

   always_ff @(posedge clk or negedge bit_cnt_rstn) begin
      if (!bit_cnt_rstn) begin
         spi_acc_q <= '0;
         int_acc_q <= '0;
      end else begin
         if (spi_issue && (spi_acc_q != 16'hFFFF)) spi_acc_q <= spi_acc_q + 16'd1;
         if (int_issue && (int_acc_q != 16'hFFFF)) int_acc_q <= int_acc_q + 16'd1;
      end
   end

   assign bus.spi_acc_cnt = spi_acc_q;
   assign bus.int_acc_cnt = int_acc_q;
`else
   assign bus.spi_acc_cnt = '0;
   assign bus.int_acc_cnt = '0;
`endif

   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_re     = mem_re_q;
   assign bus.int_gnt    = int_gnt_q;
   assign bus.int_rdata  = int_rdata_q;
   assign bus.int_rvalid = int_rvalid_q;
   assign bus.spi_rdata  = spi_rdata_q;
   assign bus.spi_rvalid = spi_rvalid_q;
   assign bus.spi_ovf    = spi_ovf_q;
   assign bus.busy       = (state != IDLE) || spi_pend;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus starvation, overflow and reset sequences.
// Works with and without MEM_ARB_STATS_EN defined.
module tb_mem_bus_arbiter;

   localparam int RD_LAT     = 2;
   localparam int STARVE_MAX = 4;

`ifdef MEM_ARB_STATS_EN
   localparam logic [15:0] EXP_SPI_ACC = 16'd3;
   localparam logic [15:0] EXP_INT_ACC = 16'd2;
`else
   localparam logic [15:0] EXP_SPI_ACC = 16'd0;
   localparam logic [15:0] EXP_INT_ACC = 16'd0;
`endif

   typedef struct {
      logic        spi;
      logic        wr;
      logic [10:0] addr;
      logic [8:0]  wdata;
      logic [8:0]  mem_val;
      logic [10:0] exp_addr;
      logic [8:0]  exp_wdata;
      logic [8:0]  exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        bit_cnt_rstn;
   logic [7:0]  re_hist = '0;
   logic [8:0]  rd_val = '0;
   int          n_tests = 0;
   int          n_fail = 0;
   vec_t        vecs [6];

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk          (clk),
      .bit_cnt_rstn (bit_cnt_rstn),
      .bus          (bus.master)
   );

   always #5 clk = ~clk;

   // Memory model: returns rd_val exactly RD_LAT cycles after the mem_re cycle, zero otherwise.
   always @(posedge clk) begin
      re_hist = {re_hist[6:0], bus.mem_re};
      #1;
      bus.mem_rdata = re_hist[RD_LAT-1] ? rd_val : 9'h000;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic outs_any();
      return |{bus.spi_rdata, bus.spi_rvalid, bus.spi_ovf, bus.int_gnt, bus.int_rdata,
               bus.int_rvalid, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re,
               bus.busy, bus.spi_acc_cnt, bus.int_acc_cnt};
   endfunction

   task automatic apply_reset();
      bit_cnt_rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 bit_cnt_rstn = 1'b1;
   endtask

   // One complete transaction with exact-cycle checks: SPI selects 1 clk after its strobe,
   // INT selects in its first req cycle; ISSUE follows selection, rvalid comes RD_LAT+2 after it.
   task automatic run_vec(input vec_t v, input string tag);
      int iss;
      int rv;
      iss = v.spi ? 2 : 1;
      rv  = iss + RD_LAT + 1;
      @(posedge clk); #1;
      rd_val = v.mem_val;
      if (v.spi) begin
         bus.spi_wr_stb = v.wr;
         bus.spi_rd_stb = !v.wr;
         bus.spi_addr   = v.addr;
         bus.spi_wdata  = v.wdata;
      end else begin
         bus.int_req   = 1'b1;
         bus.int_wr    = v.wr;
         bus.int_addr  = v.addr;
         bus.int_wdata = v.wdata;
      end
      for (int c = 0; c <= rv + 1; c++) begin
         @(negedge clk);
         if (c == iss - 1) check({tag, "_early"}, 32'(bus.mem_we | bus.mem_re), 32'd0);
         if (c == iss) begin
            check({tag, "_we"},    32'(bus.mem_we),    32'(v.wr));
            check({tag, "_re"},    32'(bus.mem_re),    32'(!v.wr));
            check({tag, "_addr"},  32'(bus.mem_addr),  32'(v.exp_addr));
            check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(v.exp_wdata));
            check({tag, "_gnt"},   32'(bus.int_gnt),   32'(!v.spi));
            check({tag, "_busy"},  32'(bus.busy),      32'd1);
         end
         if (c == iss + 1) check({tag, "_single"}, 32'(bus.mem_we | bus.mem_re | bus.int_gnt), 32'd0);
         if (!v.wr && (c == rv - 1))
            check({tag, "_rv_early"}, 32'(v.spi ? bus.spi_rvalid : bus.int_rvalid), 32'd0);
         if (!v.wr && (c == rv)) begin
            check({tag, "_rvalid"}, 32'(v.spi ? bus.spi_rvalid : bus.int_rvalid), 32'd1);
            check({tag, "_rdata"},  32'(v.spi ? bus.spi_rdata : bus.int_rdata), 32'(v.exp_rdata));
            check({tag, "_other_rv"}, 32'(v.spi ? bus.int_rvalid : bus.spi_rvalid), 32'd0);
         end
         @(posedge clk); #1;
         bus.spi_wr_stb = 1'b0;
         bus.spi_rd_stb = 1'b0;
         if (c == iss) bus.int_req = 1'b0;
      end
   endtask

   initial begin
      int gnt_cyc;
      int spi_before;
      int spi_total;
      int wr_cnt;
      int rv_seen;
      int gnt_seen;
      logic [10:0] last_addr;
      logic [8:0]  last_wdata;

      //            spi   wr    addr     wdata   mem_val  exp_addr exp_wdata exp_rdata
      vecs[0] = '{1'b1, 1'b1, 11'h123, 9'h0A5, 9'h000, 11'h123, 9'h0A5, 9'h000};
      vecs[1] = '{1'b1, 1'b0, 11'h010, 9'h000, 9'h1C3, 11'h010, 9'h000, 9'h1C3};
      vecs[2] = '{1'b0, 1'b1, 11'h7FF, 9'h1FF, 9'h000, 11'h7FF, 9'h1FF, 9'h000};
      vecs[3] = '{1'b0, 1'b0, 11'h000, 9'h00F, 9'h155, 11'h000, 9'h00F, 9'h155};
      vecs[4] = '{1'b1, 1'b1, 11'h400, 9'h000, 9'h000, 11'h400, 9'h000, 9'h000};
      vecs[5] = '{1'b0, 1'b0, 11'h2AA, 9'h101, 9'h0AA, 11'h2AA, 9'h101, 9'h0AA};

      bit_cnt_rstn   = 1'b0;
      bus.spi_wr_stb = 1'b0;
      bus.spi_rd_stb = 1'b0;
      bus.spi_addr   = '0;
      bus.spi_wdata  = '0;
      bus.int_req    = 1'b0;
      bus.int_wr     = 1'b0;
      bus.int_addr   = '0;
      bus.int_wdata  = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'(outs_any()), 32'd0);
      @(posedge clk); #1 bit_cnt_rstn = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      repeat (3) @(negedge clk);
      check("idle_hold_addr", 32'(bus.mem_addr), 32'(11'h2AA));
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_ovf", 32'(bus.spi_ovf), 32'd0);

      // Starvation: SPI strobes every 2 clks while int_req is held from cycle 1.
      gnt_cyc    = -1;
      spi_before = 0;
      spi_total  = 0;
      @(posedge clk); #1;
      for (int c = 0; c <= 16; c++) begin
         if ((c <= 8) && (c % 2 == 0)) begin
            bus.spi_wr_stb = 1'b1;
            bus.spi_addr   = 11'h100 | 11'(c);
            bus.spi_wdata  = 9'(c);
         end
         if (c == 1) begin
            bus.int_req   = 1'b1;
            bus.int_wr    = 1'b1;
            bus.int_addr  = 11'h555;
            bus.int_wdata = 9'h0AB;
         end
         @(negedge clk);
         if (bus.mem_we && (bus.mem_addr != 11'h555)) begin
            spi_total++;
            if (gnt_cyc < 0) spi_before++;
         end
         if (bus.int_gnt) begin
            gnt_cyc = c;
            check("starve_gnt_addr", 32'(bus.mem_addr), 32'(11'h555));
         end
         if (c == 9)  check("starve_cnt_sat", 32'(dut.starve_cnt), 32'(STARVE_MAX));
         if (c == 11) check("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
         @(posedge clk); #1;
         bus.spi_wr_stb = 1'b0;
         if (c == gnt_cyc) bus.int_req = 1'b0;
      end
      check("starve_gnt_cycle", 32'(gnt_cyc), 32'd10);
      check("starve_spi_before", 32'(spi_before), 32'(STARVE_MAX));
      check("starve_spi_total", 32'(spi_total), 32'd5);
      check("starve_no_ovf", 32'(bus.spi_ovf), 32'd0);

      // Overflow: two back-to-back SPI writes while an INT read sits in RD_WAIT.
      wr_cnt     = 0;
      last_addr  = '0;
      last_wdata = '0;
      @(posedge clk); #1;
      for (int c = 0; c <= 12; c++) begin
         if (c == 0) begin
            bus.int_req   = 1'b1;
            bus.int_wr    = 1'b0;
            bus.int_addr  = 11'h3C0;
            bus.int_wdata = 9'h000;
            rd_val        = 9'h0F0;
         end
         if (c == 2) begin
            bus.int_req    = 1'b0;
            bus.spi_wr_stb = 1'b1;
            bus.spi_addr   = 11'h0E1;
            bus.spi_wdata  = 9'h011;
         end
         if (c == 3) begin
            bus.spi_wr_stb = 1'b1;
            bus.spi_addr   = 11'h0E2;
            bus.spi_wdata  = 9'h022;
         end
         @(negedge clk);
         if (bus.mem_we) begin
            wr_cnt++;
            last_addr  = bus.mem_addr;
            last_wdata = bus.mem_wdata;
         end
         if (c == 1) check("ovf_int_re", 32'(bus.mem_re & bus.int_gnt), 32'd1);
         if (c == 3) check("ovf_before", 32'(bus.spi_ovf), 32'd0);
         if (c == 4) begin
            check("ovf_set", 32'(bus.spi_ovf), 32'd1);
            check("ovf_int_rvalid", 32'(bus.int_rvalid), 32'd1);
            check("ovf_int_rdata", 32'(bus.int_rdata), 32'(9'h0F0));
         end
         @(posedge clk); #1;
         bus.spi_wr_stb = 1'b0;
      end
      check("ovf_wr_count", 32'(wr_cnt), 32'd1);
      check("ovf_wr_addr", 32'(last_addr), 32'(11'h0E1));
      check("ovf_wr_data", 32'(last_wdata), 32'(9'h011));
      check("ovf_sticky", 32'(bus.spi_ovf), 32'd1);

      // Reset asserted while an INT read is in RD_WAIT.
      @(posedge clk); #1;
      bus.int_req   = 1'b1;
      bus.int_wr    = 1'b0;
      bus.int_addr  = 11'h3FF;
      bus.int_wdata = 9'h1AA;
      rd_val        = 9'h155;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_pre_issue", 32'(bus.mem_re & bus.int_gnt), 32'd1);
      check("rst_pre_addr", 32'(bus.mem_addr), 32'(11'h3FF));
      @(posedge clk); #1;
      bus.int_req = 1'b0;
      #2 bit_cnt_rstn = 1'b0;
      #1 check("rst_async_outputs", 32'(outs_any()), 32'd0);
      repeat (2) @(posedge clk);
      #1 bit_cnt_rstn = 1'b1;
      rv_seen  = 0;
      gnt_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.int_rvalid) rv_seen++;
         if (bus.int_gnt) gnt_seen++;
      end
      check("rst_no_rvalid", 32'(rv_seen), 32'd0);
      check("rst_no_gnt", 32'(gnt_seen), 32'd0);
      @(posedge clk); #1;
      bus.int_req   = 1'b1;
      bus.int_wr    = 1'b1;
      bus.int_addr  = 11'h011;
      bus.int_wdata = 9'h033;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.int_gnt) begin
            gnt_seen++;
            check("rst_regnt_we", 32'(bus.mem_we), 32'd1);
            check("rst_regnt_addr", 32'(bus.mem_addr), 32'(11'h011));
         end
         @(posedge clk); #1;
         if (gnt_seen != 0) bus.int_req = 1'b0;
      end
      check("rst_regnt_count", 32'(gnt_seen), 32'd1);

      // Access statistics after a fresh reset: 3 SPI + 2 INT issues.
      apply_reset();
      run_vec(vecs[0], "st0");
      run_vec(vecs[1], "st1");
      run_vec(vecs[2], "st2");
      run_vec(vecs[3], "st3");
      run_vec(vecs[4], "st4");
      @(negedge clk);
      check("stats_spi", 32'(bus.spi_acc_cnt), 32'(EXP_SPI_ACC));
      check("stats_int", 32'(bus.int_acc_cnt), 32'(EXP_INT_ACC));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
